power_pack_ctrl: RTL and testbench
==================================

# power_pack_ctrl

Game-side controller for the power pack: decides when a pack spawns, detects the ball collecting it, and applies the timed effect. It drives the `spawn`/`eaten` inputs of the power-pack spawner and receives back that block's `rx`/`ry`/`mode`. Its effect-enable outputs feed the ball-speed and paddle/score logic of the Pong top level. All timing is counted in video frames.

## Interface
- `WIDTH`, 20, pack width in pixels; must match the spawner.
- `HEIGHT`, 20, pack height in pixels; must match the spawner.
- `BALL_SIZE`, 16, ball square side in pixels.
- `COOLDOWN_FRAMES`, 120, frames between an effect ending and the next spawn (1..1023).
- `ARMED_FRAMES`, 600, frames an uncollected pack stays before forced respawn (1..1023).
- `EFFECT_FRAMES`, 300, duration of SLOW/BOOST/SHIELD (1..1023).

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: reset, asynchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per frame.
- `game_active` in 1: high while a rally is in play.
- `ball_x` in 11 / `ball_y` in 10: ball top-left.
- `last_hitter` in 1: 0 = P1, 1 = P2; last paddle to touch the ball.
- `pp_x` in 11 / `pp_y` in 10 / `pp_mode` in 2: spawner position and mode.
- `spawn` out 1: one-cycle spawn request to the spawner.
- `eaten` out 1: one-cycle collect/clear pulse to the spawner.
- `slow_en`, `boost_en` out 1: ball speed modifiers.
- `shield_p1`, `shield_p2` out 1: goal shield per player.
- `extra_life` out 1: one-cycle pulse.
- `owner` out 1: player credited with the current/last pack.

## Operation
- Mode encoding: 00 SLOW, 01 BOOST, 10 EXTRA, 11 SHIELD.
- Frame counter `fcnt` is 10 bits. It is loaded on state entry and decrements on `frame_tick`. Expiry is `frame_tick` while `fcnt==1`.
- States:
  - **IDLE**: `fcnt`=COOLDOWN_FRAMES. Stay while `!game_active`. On expiry go to SPAWN.
  - **SPAWN**: one cycle; `spawn`=1. Then go to ARMED with `fcnt`=ARMED_FRAMES.
  - **ARMED**: compare every cycle. On hit, go to EATEN. On expiry with no hit, go to SPAWN (respawn at a new location). On `!game_active`, go to CLEAR.
  - **EATEN**: one cycle; `eaten`=1. Latch `pp_mode` into `mode_q` and `last_hitter` into `owner`.
    - EXTRA: pulse `extra_life` in this cycle, then go to IDLE.
    - Otherwise: go to EFFECT with `fcnt`=EFFECT_FRAMES.
  - **EFFECT**: drive the enable selected by `mode_q`. SHIELD drives `shield_p1` if `owner`=0, else `shield_p2`. On expiry or `!game_active`, go to IDLE.
  - **CLEAR**: one cycle; `eaten`=1 with no effect and `owner` unchanged. Then go to IDLE.
- Hit test: strict box overlap, computed in 12-bit unsigned so sums do not wrap:
  - `ball_x < pp_x+WIDTH`
  - `ball_x+BALL_SIZE > pp_x`
  - `ball_y < pp_y+HEIGHT`
  - `ball_y+BALL_SIZE > pp_y`
- Priority in ARMED: `!game_active` > hit > expiry.
- Effect outputs are registered, decoded from state and `mode_q`. At most one of `slow_en`/`boost_en`/`shield_*` is high at any time.
- A pack the spawner shows straight out of its own reset is ignored until this block's first SPAWN.

## Timing
- Reset values: state IDLE, `fcnt`=COOLDOWN_FRAMES, `mode_q`=00, `owner`=0. All outputs 0.
- `spawn`, `eaten` and `extra_life` are exactly one cycle wide and never high in the same cycle.
- The spawner updates `pp_x`/`pp_y`/`pp_mode` on the edge that samples `spawn`. The first hit comparison is in the first ARMED cycle, which sees the new values.
- Hit latency: a hit present at edge N (state ARMED) gives `eaten`=1 in cycle N+1. Effect outputs rise in cycle N+2.
- Effect length: high from EFFECT entry until the edge after the EFFECT_FRAMES-th `frame_tick`. They drop on the cycle IDLE is entered.
- `frame_tick` in the same cycle as a SPAWN/EATEN/CLEAR state is ignored. The counter restarts on entry to the next state.
- `reset` mid-effect clears all outputs asynchronously. No `eaten` is issued for an on-screen pack; the next SPAWN relocates it.

## Test plan
- Bench parameters: COOLDOWN=2, ARMED=4, EFFECT=3, `frame_tick` every 10 cycles, `game_active`=1.
- Reset, then 2 ticks → `spawn` 1 cycle. Drive `pp_x`=400, `pp_y`=300, `pp_mode`=00. Ball at (100,100) for 4 ticks → second `spawn`, no `eaten`.
- Armed, ball (390,290), `last_hitter`=1 (overlap; boundary ball_x+16=406 > 400) → `eaten` next cycle, `slow_en`=1 the cycle after, held for 3 ticks, then 0. Ball (384,290) (384+16=400, not >) → no hit.
- `pp_mode`=11, `last_hitter`=0, hit → `shield_p1`=1 and `shield_p2`=0 for 3 ticks. `pp_mode`=10 → `extra_life` pulses in the same cycle as `eaten`, no enables, cooldown restarts.
- Armed, drop `game_active` in the same cycle as a hit → `eaten` pulse with no effect outputs; `owner` unchanged; stays IDLE until `game_active` returns.
- Assert `reset` mid-BOOST → `boost_en` falls without waiting for a clock edge. After release, the next `spawn` comes exactly 2 ticks later.

Source files
------------

// File: rtl/power_pack_ctrl_if.sv
// Game-side bundle between the power-pack controller, the spawner and the ball/paddle logic.
// No latency of its own; plain wires.
// No backpressure: every signal is a level or a single-cycle pulse.
interface power_pack_ctrl_if;
    logic        frame_tick;
    logic        game_active;
    logic [10:0] ball_x;
    logic [9:0]  ball_y;
    logic        last_hitter;
    logic [10:0] pp_x;
    logic [9:0]  pp_y;
    logic [1:0]  pp_mode;
    logic        spawn;
    logic        eaten;
    logic        slow_en;
    logic        boost_en;
    logic        shield_p1;
    logic        shield_p2;
    logic        extra_life;
    logic        owner;

    modport master (
        input  frame_tick, game_active, ball_x, ball_y, last_hitter, pp_x, pp_y, pp_mode,
        output spawn, eaten, slow_en, boost_en, shield_p1, shield_p2, extra_life, owner
    );

    modport slave (
        output frame_tick, game_active, ball_x, ball_y, last_hitter, pp_x, pp_y, pp_mode,
        input  spawn, eaten, slow_en, boost_en, shield_p1, shield_p2, extra_life, owner
    );
endinterface

// File: rtl/power_pack_ctrl.sv
// Power-pack controller: spawn timing, ball/pack collision, timed SLOW/BOOST/SHIELD/EXTRA effects.
// Latency: hit sampled at edge N -> eaten in cycle N+1 -> effect enables from cycle N+2.
// No backpressure; spawner and effect consumers must accept every pulse/level as issued.
module power_pack_ctrl #(
    parameter int WIDTH           = 20,
    parameter int HEIGHT          = 20,
    parameter int BALL_SIZE       = 16,
    parameter int COOLDOWN_FRAMES = 120,
    parameter int ARMED_FRAMES    = 600,
    parameter int EFFECT_FRAMES   = 300
) (
    input  logic              clk,
    input  logic              reset,
    power_pack_ctrl_if.master pp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_ARMED,
        S_EATEN,
        S_EFFECT,
        S_CLEAR
    } state_t;

    localparam logic [1:0] MODE_SLOW   = 2'b00;
    localparam logic [1:0] MODE_BOOST  = 2'b01;
    localparam logic [1:0] MODE_EXTRA  = 2'b10;
    localparam logic [1:0] MODE_SHIELD = 2'b11;

    localparam logic [9:0] COOL_LD = 10'(COOLDOWN_FRAMES);
    localparam logic [9:0] ARM_LD  = 10'(ARMED_FRAMES);
    localparam logic [9:0] EFF_LD  = 10'(EFFECT_FRAMES);

    state_t     state_q, state_d;
    logic [9:0] fcnt_q, fcnt_d;
    logic [1:0] mode_q, mode_d;
    logic       owner_q, owner_d;
    logic       spawn_q, spawn_d;
    logic       eaten_q, eaten_d;
    logic       extra_q, extra_d;
    logic       slow_q, slow_d;
    logic       boost_q, boost_d;
    logic       shp1_q, shp1_d;
    logic       shp2_q, shp2_d;

    // 12-bit operands keep pp_x+WIDTH and ball+BALL_SIZE from wrapping at the screen edge.
    logic [11:0] bx, by, px, py;
    logic        hit, expire, in_effect;

    assign bx = {1'b0, pp.ball_x};
    assign by = {2'b00, pp.ball_y};
    assign px = {1'b0, pp.pp_x};
    assign py = {2'b00, pp.pp_y};

    assign hit = (bx < px + 12'(WIDTH)) && (bx + 12'(BALL_SIZE) > px) &&
                 (by < py + 12'(HEIGHT)) && (by + 12'(BALL_SIZE) > py);

    assign expire = pp.frame_tick && (fcnt_q == 10'd1);

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        mode_d  = mode_q;
        owner_d = owner_q;
        spawn_d = 1'b0;
        eaten_d = 1'b0;
        extra_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Cooldown is frozen, not restarted, while the rally is paused.
                if (pp.game_active) begin
                    if (expire) begin
                        state_d = S_SPAWN;
                        spawn_d = 1'b1;
                    end else if (pp.frame_tick) begin
                        fcnt_d = fcnt_q - 10'd1;
                    end
                end
            end
            S_SPAWN: begin
                state_d = S_ARMED;
                fcnt_d  = ARM_LD;
            end
            S_ARMED: begin
                if (!pp.game_active) begin
                    state_d = S_CLEAR;
                    eaten_d = 1'b1;
                end else if (hit) begin
                    state_d = S_EATEN;
                    eaten_d = 1'b1;
                    mode_d  = pp.pp_mode;
                    owner_d = pp.last_hitter;
                    extra_d = (pp.pp_mode == MODE_EXTRA);
                end else if (expire) begin
                    state_d = S_SPAWN;
                    spawn_d = 1'b1;
                end else if (pp.frame_tick) begin
                    fcnt_d = fcnt_q - 10'd1;
                end
            end
            S_EATEN: begin
                if (mode_q == MODE_EXTRA) begin
                    state_d = S_IDLE;
                    fcnt_d  = COOL_LD;
                end else begin
                    state_d = S_EFFECT;
                    fcnt_d  = EFF_LD;
                end
            end
            S_EFFECT: begin
                if (!pp.game_active || expire) begin
                    state_d = S_IDLE;
                    fcnt_d  = COOL_LD;
                end else if (pp.frame_tick) begin
                    fcnt_d = fcnt_q - 10'd1;
                end
            end
            S_CLEAR: begin
                state_d = S_IDLE;
                fcnt_d  = COOL_LD;
            end
            default: begin
                state_d = S_IDLE;
                fcnt_d  = COOL_LD;
            end
        endcase
    end

    // Enables are decoded from the next state so they register exactly on EFFECT entry/exit.
    assign in_effect = (state_d == S_EFFECT);
    assign slow_d    = in_effect && (mode_d == MODE_SLOW);
    assign boost_d   = in_effect && (mode_d == MODE_BOOST);
    assign shp1_d    = in_effect && (mode_d == MODE_SHIELD) && !owner_d;
    assign shp2_d    = in_effect && (mode_d == MODE_SHIELD) &&  owner_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            fcnt_q  <= COOL_LD;
            mode_q  <= MODE_SLOW;
            owner_q <= 1'b0;
            spawn_q <= 1'b0;
            eaten_q <= 1'b0;
            extra_q <= 1'b0;
            slow_q  <= 1'b0;
            boost_q <= 1'b0;
            shp1_q  <= 1'b0;
            shp2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            mode_q  <= mode_d;
            owner_q <= owner_d;
            spawn_q <= spawn_d;
            eaten_q <= eaten_d;
            extra_q <= extra_d;
            slow_q  <= slow_d;
            boost_q <= boost_d;
            shp1_q  <= shp1_d;
            shp2_q  <= shp2_d;
        end
    end

    assign pp.spawn      = spawn_q;
    assign pp.eaten      = eaten_q;
    assign pp.extra_life = extra_q;
    assign pp.slow_en    = slow_q;
    assign pp.boost_en   = boost_q;
    assign pp.shield_p1  = shp1_q;
    assign pp.shield_p2  = shp2_q;
    assign pp.owner      = owner_q;

endmodule

// File: tb/tb_power_pack_ctrl.sv
// Directed bench for power_pack_ctrl: cooldown/armed/effect timing, hit boundaries, CLEAR and async reset.
// Short frame constants and a frame_tick every 10 cycles keep every expected latency hand-computable.
// Inputs change 1 ns after the rising edge; outputs are read at the same point.
module tb_power_pack_ctrl;

    localparam int SEL_SPAWN  = 0;
    localparam int SEL_EATEN  = 1;
    localparam int SEL_SLOW   = 2;
    localparam int SEL_BOOST  = 3;
    localparam int SEL_SHP1   = 4;
    localparam int SEL_EXTRA  = 5;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;
    int n_ticks  = 0;
    int n_spawn  = 0;
    int n_eaten  = 0;
    int n_extra  = 0;
    int n_viol   = 0;

    power_pack_ctrl_if pp();

    power_pack_ctrl #(
        .WIDTH          (20),
        .HEIGHT         (20),
        .BALL_SIZE      (16),
        .COOLDOWN_FRAMES(2),
        .ARMED_FRAMES   (4),
        .EFFECT_FRAMES  (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .pp   (pp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        int tph;
        tph = 0;
        pp.frame_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pp.frame_tick = (tph == 9);
            tph = (tph == 9) ? 0 : tph + 1;
        end
    end

    always @(posedge clk) begin
        if (pp.frame_tick && !reset) n_ticks++;
    end

    always @(negedge clk) begin
        if (pp.spawn)      n_spawn++;
        if (pp.eaten)      n_eaten++;
        if (pp.extra_life) n_extra++;
        if ((int'(pp.slow_en) + int'(pp.boost_en) + int'(pp.shield_p1) + int'(pp.shield_p2)) > 1 ||
            (pp.spawn && pp.eaten))
            n_viol++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SEL_SPAWN: return pp.spawn;
            SEL_EATEN: return pp.eaten;
            SEL_SLOW:  return pp.slow_en;
            SEL_BOOST: return pp.boost_en;
            SEL_SHP1:  return pp.shield_p1;
            SEL_EXTRA: return pp.extra_life;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic int outs();
        return int'({pp.spawn, pp.eaten, pp.slow_en, pp.boost_en,
                     pp.shield_p1, pp.shield_p2, pp.extra_life});
    endfunction

    function automatic int enables();
        return int'({pp.slow_en, pp.boost_en, pp.shield_p1, pp.shield_p2});
    endfunction

    // Returns budget+1 when the level never appears, so the caller's latency check fails.
    task automatic wait_lvl(input int sel, input logic lvl, input int budget, output int cyc);
        cyc = budget + 1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (sig(sel) == lvl) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic set_ball(input int x, input int y);
        pp.ball_x = 11'(x);
        pp.ball_y = 10'(y);
    endtask

    initial begin
        int cyc;
        int t0;
        int e0;

        reset          = 1'b1;
        pp.game_active = 1'b1;
        pp.last_hitter = 1'b0;
        pp.pp_x        = 11'd0;
        pp.pp_y        = 10'd0;
        pp.pp_mode     = 2'b00;
        set_ball(100, 100);

        repeat (3) step();
        chk("reset_outputs", outs(), 0);
        chk("reset_owner", int'(pp.owner), 0);
        reset = 1'b0;
        t0 = n_ticks;

        // Cooldown of 2 ticks, then a single-cycle spawn.
        wait_lvl(SEL_SPAWN, 1'b1, 60, cyc);
        chk("first_spawn_ticks", n_ticks - t0, 2);
        pp.pp_x    = 11'd400;
        pp.pp_y    = 10'd300;
        pp.pp_mode = 2'b00;
        t0 = n_ticks;
        step();
        chk("spawn_width", int'(pp.spawn), 0);

        // Ball far away: armed window of 4 ticks expires into a respawn.
        wait_lvl(SEL_SPAWN, 1'b1, 60, cyc);
        chk("armed_expiry_ticks", n_ticks - t0, 4);
        chk("no_eaten_on_miss", n_eaten, 0);

        // SLOW hit on the x boundary (390+16 = 406 > 400), credited to P2.
        set_ball(390, 290);
        pp.last_hitter = 1'b1;
        wait_lvl(SEL_EATEN, 1'b1, 5, cyc);
        chk("slow_eaten_latency", cyc, 2);
        chk("slow_owner", int'(pp.owner), 1);
        chk("slow_not_yet", int'(pp.slow_en), 0);
        step();
        chk("slow_rise", int'(pp.slow_en), 1);
        chk("eaten_width", int'(pp.eaten), 0);
        set_ball(384, 290);
        t0 = n_ticks;
        wait_lvl(SEL_SLOW, 1'b0, 60, cyc);
        chk("slow_high_cycles", cyc, 27);
        chk("slow_ticks", n_ticks - t0, 3);
        wait_lvl(SEL_SPAWN, 1'b1, 40, cyc);
        chk("cooldown_after_slow", cyc, 20);

        // Ball touching edge only (384+16 = 400, not > 400): no hit, armed times out.
        e0 = n_eaten;
        wait_lvl(SEL_SPAWN, 1'b1, 60, cyc);
        chk("edge_touch_respawn", cyc, 40);
        chk("edge_touch_no_eaten", n_eaten, e0);

        // SHIELD credited to P1.
        pp.pp_mode     = 2'b11;
        pp.last_hitter = 1'b0;
        set_ball(390, 290);
        wait_lvl(SEL_EATEN, 1'b1, 5, cyc);
        chk("shield_eaten_latency", cyc, 2);
        chk("shield_owner", int'(pp.owner), 0);
        step();
        chk("shield_p1_rise", int'(pp.shield_p1), 1);
        chk("shield_p2_low", int'(pp.shield_p2), 0);
        wait_lvl(SEL_SHP1, 1'b0, 60, cyc);
        chk("shield_high_cycles", cyc, 27);
        wait_lvl(SEL_SPAWN, 1'b1, 40, cyc);
        chk("cooldown_after_shield", cyc, 20);

        // EXTRA: extra_life alongside eaten, no enables, cooldown restarts.
        pp.pp_mode = 2'b10;
        wait_lvl(SEL_EATEN, 1'b1, 5, cyc);
        chk("extra_eaten_latency", cyc, 2);
        chk("extra_with_eaten", int'(pp.extra_life), 1);
        step();
        chk("extra_width", int'(pp.extra_life), 0);
        chk("extra_no_enables", enables(), 0);
        wait_lvl(SEL_SPAWN, 1'b1, 40, cyc);
        chk("cooldown_after_extra", cyc, 17);

        // Rally stops in the same cycle as a hit: CLEAR, owner kept, held in IDLE.
        pp.pp_mode     = 2'b01;
        pp.last_hitter = 1'b1;
        pp.game_active = 1'b0;
        wait_lvl(SEL_EATEN, 1'b1, 5, cyc);
        chk("clear_eaten_latency", cyc, 2);
        chk("clear_owner_kept", int'(pp.owner), 0);
        step();
        chk("clear_no_enables", enables(), 0);
        repeat (60) step();
        chk("idle_while_inactive", n_spawn, 6);
        pp.game_active = 1'b1;
        wait_lvl(SEL_SPAWN, 1'b1, 60, cyc);
        chk("spawn_after_resume", int'(cyc <= 60), 1);

        // BOOST, then asynchronous reset between clock edges.
        wait_lvl(SEL_EATEN, 1'b1, 5, cyc);
        chk("boost_eaten_latency", cyc, 2);
        step();
        chk("boost_rise", int'(pp.boost_en), 1);
        chk("boost_owner", int'(pp.owner), 1);
        repeat (4) step();
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_boost", int'(pp.boost_en), 0);
        chk("async_reset_outputs", outs(), 0);
        chk("async_reset_owner", int'(pp.owner), 0);
        repeat (3) step();
        reset = 1'b0;
        t0 = n_ticks;
        wait_lvl(SEL_SPAWN, 1'b1, 40, cyc);
        chk("spawn_after_reset_ticks", n_ticks - t0, 2);
        step();

        chk("total_spawn_cycles", n_spawn, 8);
        chk("total_eaten_cycles", n_eaten, 5);
        chk("total_extra_cycles", n_extra, 1);
        chk("exclusivity_violations", n_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
